// File: rtl/urisc_pkg.sv
// rtl/urisc_pkg.sv - opcodes, micro-op encodings and decode helpers for decode_issue
package urisc_pkg;

  localparam int UOP_W = 26;
  localparam int XLEN  = 16;

  // Major opcodes, inst[15:11]
  localparam logic [4:0] OP_HALT   = 5'b00000;
  localparam logic [4:0] OP_NOP    = 5'b00001;
  localparam logic [4:0] OP_SIIC   = 5'b00010;
  localparam logic [4:0] OP_J      = 5'b00100;
  localparam logic [4:0] OP_JR     = 5'b00101;
  localparam logic [4:0] OP_JAL    = 5'b00110;
  localparam logic [4:0] OP_JALR   = 5'b00111;
  localparam logic [4:0] OP_ADDI   = 5'b01000;
  localparam logic [4:0] OP_SUBI   = 5'b01001;
  localparam logic [4:0] OP_XORI   = 5'b01010;
  localparam logic [4:0] OP_ANDNI  = 5'b01011;
  localparam logic [4:0] OP_BEQZ   = 5'b01100;
  localparam logic [4:0] OP_BNEZ   = 5'b01101;
  localparam logic [4:0] OP_BLTZ   = 5'b01110;
  localparam logic [4:0] OP_BGEZ   = 5'b01111;
  localparam logic [4:0] OP_ST     = 5'b10000;
  localparam logic [4:0] OP_LD     = 5'b10001;
  localparam logic [4:0] OP_SLBI   = 5'b10010;
  localparam logic [4:0] OP_STU    = 5'b10011;
  localparam logic [4:0] OP_ROLI   = 5'b10100;
  localparam logic [4:0] OP_SLLI   = 5'b10101;
  localparam logic [4:0] OP_RORI   = 5'b10110;
  localparam logic [4:0] OP_SRLI   = 5'b10111;
  localparam logic [4:0] OP_LBI    = 5'b11000;
  localparam logic [4:0] OP_BTR    = 5'b11001;
  localparam logic [4:0] OP_RSHIFT = 5'b11010;
  localparam logic [4:0] OP_RALU   = 5'b11011;
  localparam logic [4:0] OP_SEQ    = 5'b11100;
  localparam logic [4:0] OP_SLT    = 5'b11101;
  localparam logic [4:0] OP_SLE    = 5'b11110;
  localparam logic [4:0] OP_SCO    = 5'b11111;

  // One-hot micro-op select; UOP_NONE marks HALT/NOP/SIIC
  typedef enum logic [UOP_W-1:0] {
    UOP_NONE = 26'h0000000,
    UOP_ADD  = 26'h0000001, UOP_SUB  = 26'h0000002, UOP_XOR  = 26'h0000004,
    UOP_ANDN = 26'h0000008, UOP_ROL  = 26'h0000010, UOP_SLL  = 26'h0000020,
    UOP_ROR  = 26'h0000040, UOP_SRL  = 26'h0000080, UOP_SEQ  = 26'h0000100,
    UOP_SLT  = 26'h0000200, UOP_SLE  = 26'h0000400, UOP_SCO  = 26'h0000800,
    UOP_BTR  = 26'h0001000, UOP_LBI  = 26'h0002000, UOP_SLBI = 26'h0004000,
    UOP_LD   = 26'h0008000, UOP_ST   = 26'h0010000, UOP_STU  = 26'h0020000,
    UOP_BEQZ = 26'h0040000, UOP_BNEZ = 26'h0080000, UOP_BLTZ = 26'h0100000,
    UOP_BGEZ = 26'h0200000, UOP_J    = 26'h0400000, UOP_JR   = 26'h0800000,
    UOP_JAL  = 26'h1000000, UOP_JALR = 26'h2000000
  } uop_e;

  typedef struct packed {
    logic             execute_valid;
    logic             ldst_valid;
    logic             jmp;
    logic             branch;
    logic [4:0]       opcode;
    logic             rsr;
    logic [UOP_W-1:0] uop;
    logic [2:0]       rs;
    logic [2:0]       rt;
    logic [2:0]       rd;
    logic             wr;
    logic             excep;
    logic             halt;
    logic             stu;
  } idix_t;

  // Destination index depends on the instruction format
  function automatic logic [2:0] rd_select(input logic [4:0] op, input logic [2:0] f_rs,
                                           input logic [2:0] f_rt, input logic [2:0] f_rd);
    logic [2:0] rd;
    case (op)
      OP_LBI, OP_SLBI: rd = f_rs;
      OP_JAL, OP_JALR: rd = 3'd7;
      OP_BTR, OP_RSHIFT, OP_RALU, OP_SEQ, OP_SLT, OP_SLE, OP_SCO: rd = f_rd;
      default: rd = f_rt;
    endcase
    return rd;
  endfunction

  // Within each group of four opcodes the low two bits pick the operation
  function automatic logic [UOP_W-1:0] group_uop(input logic [1:0] grp, input logic [1:0] sel);
    logic [UOP_W-1:0] u;
    u = UOP_NONE;
    case ({grp, sel})
      4'b0000: u = UOP_ADD;  4'b0001: u = UOP_SUB;  4'b0010: u = UOP_XOR;  4'b0011: u = UOP_ANDN;
      4'b0100: u = UOP_ROL;  4'b0101: u = UOP_SLL;  4'b0110: u = UOP_ROR;  4'b0111: u = UOP_SRL;
      4'b1000: u = UOP_SEQ;  4'b1001: u = UOP_SLT;  4'b1010: u = UOP_SLE;  4'b1011: u = UOP_SCO;
      4'b1100: u = UOP_BEQZ; 4'b1101: u = UOP_BNEZ; 4'b1110: u = UOP_BLTZ; 4'b1111: u = UOP_BGEZ;
      default: u = UOP_NONE;
    endcase
    return u;
  endfunction

  function automatic idix_t decode(input logic [XLEN-1:0] inst);
    idix_t      d;
    logic [4:0] op;
    op       = inst[15:11];
    d        = '0;
    d.opcode = op;
    d.rs     = inst[10:8];
    d.rt     = inst[7:5];
    d.rd     = rd_select(op, inst[10:8], inst[7:5], inst[4:2]);
    case (op)
      OP_HALT: d.halt  = 1'b1;
      OP_SIIC: d.excep = 1'b1;
      OP_J:    begin d.jmp = 1'b1; d.uop = UOP_J; end
      OP_JR:   begin d.jmp = 1'b1; d.uop = UOP_JR; end
      OP_JAL:  begin d.jmp = 1'b1; d.wr = 1'b1; d.uop = UOP_JAL; end
      OP_JALR: begin d.jmp = 1'b1; d.wr = 1'b1; d.uop = UOP_JALR; end
      OP_ADDI, OP_SUBI, OP_XORI, OP_ANDNI: begin
        d.execute_valid = 1'b1; d.wr = 1'b1; d.uop = group_uop(2'd0, op[1:0]);
      end
      OP_ROLI, OP_SLLI, OP_RORI, OP_SRLI: begin
        d.execute_valid = 1'b1; d.wr = 1'b1; d.uop = group_uop(2'd1, op[1:0]); d.rsr = op[1];
      end
      OP_BEQZ, OP_BNEZ, OP_BLTZ, OP_BGEZ: begin
        d.branch = 1'b1; d.uop = group_uop(2'd3, op[1:0]);
      end
      OP_ST:   begin d.ldst_valid = 1'b1; d.uop = UOP_ST; end
      OP_LD:   begin d.ldst_valid = 1'b1; d.wr = 1'b1; d.uop = UOP_LD; end
      OP_STU:  begin d.ldst_valid = 1'b1; d.stu = 1'b1; d.uop = UOP_STU; end
      OP_LBI:  begin d.execute_valid = 1'b1; d.wr = 1'b1; d.uop = UOP_LBI; end
      OP_SLBI: begin d.execute_valid = 1'b1; d.wr = 1'b1; d.uop = UOP_SLBI; end
      OP_BTR:  begin d.execute_valid = 1'b1; d.wr = 1'b1; d.uop = UOP_BTR; end
      OP_RALU: begin
        d.execute_valid = 1'b1; d.wr = 1'b1; d.uop = group_uop(2'd0, inst[1:0]);
      end
      OP_RSHIFT: begin
        d.execute_valid = 1'b1; d.wr = 1'b1; d.uop = group_uop(2'd1, inst[1:0]); d.rsr = inst[1];
      end
      OP_SEQ, OP_SLT, OP_SLE, OP_SCO: begin
        d.execute_valid = 1'b1; d.wr = 1'b1; d.uop = group_uop(2'd2, op[1:0]);
      end
      default: ; // NOP and unassigned opcodes issue as a plain bubble uop
    endcase
    return d;
  endfunction

endpackage

// File: rtl/decode_comb.sv
// rtl/decode_comb.sv - combinational instruction to idix_t decoder
module decode_comb import urisc_pkg::*; (
  input  logic [XLEN-1:0] i_inst,
  output idix_t           o_idix
);

  assign o_idix = decode(i_inst);

endmodule

// File: rtl/decode_issue.sv
// rtl/decode_issue.sv - decode stage driving the idix_p1 register with skid buffer and uop sequencing
module decode_issue #(
  parameter int UOP_W = 26,
  parameter int XLEN  = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             if_valid,
  input  logic [XLEN-1:0]  if_inst,
  input  logic [XLEN-1:0]  if_pc,
  output logic             if_ready,
  input  logic             ex_ready,
  input  logic             flush,
  output logic             valid_idix_p1,
  output logic             execute_valid_idix_p1,
  output logic             ldst_valid_idix_p1,
  output logic             jmp_idix_p1,
  output logic             branch_idix_p1,
  output logic [4:0]       opcode_idix_p1,
  output logic             rotate_shift_right_idix_p1,
  output logic [UOP_W-1:0] uop_cnt_idix_p1,
  output logic [2:0]       rs_idix_p1,
  output logic [2:0]       rt_idix_p1,
  output logic [2:0]       rd_idix_p1,
  output logic             wr_idix_p1,
  output logic             excep_idix_p1,
  output logic [XLEN-1:0]  pc_p1,
  output logic [XLEN-1:0]  inst_idix_p1,
  output logic             halted
);
  import urisc_pkg::*;

  typedef enum logic [1:0] {S_RUN, S_UOP2, S_HALT} state_e;

  state_e          r_state, w_state_nx;
  logic            r_ready, w_ready_nx;
  logic            r_halted, w_halted_nx;
  logic            r_valid, w_valid_nx;
  idix_t           r_idix, w_idix_nx, w_dec;
  logic [XLEN-1:0] r_pc, w_pc_nx, r_inst, w_inst_nx;
  logic            r_skid_v, w_skid_v_nx;
  logic [XLEN-1:0] r_skid_inst, w_skid_inst_nx, r_skid_pc, w_skid_pc_nx;
  logic            w_adv, w_acc;
  logic [XLEN-1:0] w_src_inst, w_src_pc;

  assign w_adv      = !r_valid || ex_ready;
  assign w_acc      = if_valid && r_ready && !flush;
  // The skid entry is always older than anything on the input port
  assign w_src_inst = r_skid_v ? r_skid_inst : if_inst;
  assign w_src_pc   = r_skid_v ? r_skid_pc   : if_pc;

  decode_comb u_decode_comb (
    .i_inst (w_src_inst),
    .o_idix (w_dec)
  );

  // Next-state, idix load selection and skid capture
  always_comb begin
    w_state_nx     = r_state;
    w_halted_nx    = r_halted;
    w_valid_nx     = r_valid;
    w_idix_nx      = r_idix;
    w_pc_nx        = r_pc;
    w_inst_nx      = r_inst;
    w_skid_v_nx    = r_skid_v;
    w_skid_inst_nx = r_skid_inst;
    w_skid_pc_nx   = r_skid_pc;
    if (flush) begin
      w_state_nx  = S_RUN;
      w_halted_nx = 1'b0;
      w_valid_nx  = 1'b0;
      w_idix_nx   = '0;
      w_pc_nx     = '0;
      w_inst_nx   = '0;
      w_skid_v_nx = 1'b0;
    end else if (w_adv) begin
      if (r_skid_v || (r_state == S_RUN && w_acc)) begin
        w_valid_nx  = 1'b1;
        w_idix_nx   = w_dec;
        w_pc_nx     = w_src_pc;
        w_inst_nx   = w_src_inst;
        w_skid_v_nx = 1'b0;
        if (w_dec.stu) begin
          w_state_nx = S_UOP2;
        end else if (w_dec.halt) begin
          w_state_nx  = S_HALT;
          w_halted_nx = 1'b1;
        end
      end else if (r_state == S_UOP2) begin
        // Second STU uop: base register writeback, same pc/inst as the store
        w_valid_nx              = 1'b1;
        w_idix_nx.ldst_valid    = 1'b0;
        w_idix_nx.execute_valid = 1'b1;
        w_idix_nx.wr            = 1'b1;
        w_idix_nx.rd            = r_idix.rs;
        w_idix_nx.uop           = UOP_ADD;
        w_idix_nx.stu           = 1'b0;
        w_state_nx              = S_RUN;
      end else begin
        w_valid_nx = 1'b0;
        w_idix_nx  = '0;
        w_pc_nx    = '0;
        w_inst_nx  = '0;
      end
    end else if (w_acc) begin
      w_skid_v_nx    = 1'b1;
      w_skid_inst_nx = if_inst;
      w_skid_pc_nx   = if_pc;
    end
    w_ready_nx = (w_state_nx == S_RUN) && !w_skid_v_nx;
  end

  // Control state register
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= S_RUN;
      r_ready  <= 1'b0;
      r_halted <= 1'b0;
      r_valid  <= 1'b0;
      r_skid_v <= 1'b0;
    end else begin
      r_state  <= w_state_nx;
      r_ready  <= w_ready_nx;
      r_halted <= w_halted_nx;
      r_valid  <= w_valid_nx;
      r_skid_v <= w_skid_v_nx;
    end
  end

  // idix pipeline register and skid payload
  always_ff @(posedge clk) begin
    if (rst) begin
      r_idix      <= '0;
      r_pc        <= '0;
      r_inst      <= '0;
      r_skid_inst <= '0;
      r_skid_pc   <= '0;
    end else begin
      r_idix      <= w_idix_nx;
      r_pc        <= w_pc_nx;
      r_inst      <= w_inst_nx;
      r_skid_inst <= w_skid_inst_nx;
      r_skid_pc   <= w_skid_pc_nx;
    end
  end

  assign if_ready                   = r_ready;
  assign halted                     = r_halted;
  assign valid_idix_p1              = r_valid;
  assign execute_valid_idix_p1      = r_idix.execute_valid;
  assign ldst_valid_idix_p1         = r_idix.ldst_valid;
  assign jmp_idix_p1                = r_idix.jmp;
  assign branch_idix_p1             = r_idix.branch;
  assign opcode_idix_p1             = r_idix.opcode;
  assign rotate_shift_right_idix_p1 = r_idix.rsr;
  assign uop_cnt_idix_p1            = r_idix.uop;
  assign rs_idix_p1                 = r_idix.rs;
  assign rt_idix_p1                 = r_idix.rt;
  assign rd_idix_p1                 = r_idix.rd;
  assign wr_idix_p1                 = r_idix.wr;
  assign excep_idix_p1              = r_idix.excep;
  assign pc_p1                      = r_pc;
  assign inst_idix_p1               = r_inst;

endmodule

// File: tb/tb_decode_issue.sv
// tb/tb_decode_issue.sv - directed self-checking bench for decode_issue
module tb_decode_issue;

  logic        clk = 1'b0;
  logic        rst, if_valid, ex_ready, flush;
  logic [15:0] if_inst, if_pc;
  logic        if_ready, valid_idix_p1, execute_valid_idix_p1, ldst_valid_idix_p1;
  logic        jmp_idix_p1, branch_idix_p1, rotate_shift_right_idix_p1;
  logic [4:0]  opcode_idix_p1;
  logic [25:0] uop_cnt_idix_p1;
  logic [2:0]  rs_idix_p1, rt_idix_p1, rd_idix_p1;
  logic        wr_idix_p1, excep_idix_p1, halted;
  logic [15:0] pc_p1, inst_idix_p1;

  int          n_tests = 0;
  int          n_fail  = 0;
  int          k, cnt_rdy, cnt_vld;
  logic [31:0] iss_pc[$];
  int          iss_cyc[$];

  always #5 clk = ~clk;

  decode_issue #(.UOP_W(26), .XLEN(16)) dut (
    .clk                        (clk),
    .rst                        (rst),
    .if_valid                   (if_valid),
    .if_inst                    (if_inst),
    .if_pc                      (if_pc),
    .if_ready                   (if_ready),
    .ex_ready                   (ex_ready),
    .flush                      (flush),
    .valid_idix_p1              (valid_idix_p1),
    .execute_valid_idix_p1      (execute_valid_idix_p1),
    .ldst_valid_idix_p1         (ldst_valid_idix_p1),
    .jmp_idix_p1                (jmp_idix_p1),
    .branch_idix_p1             (branch_idix_p1),
    .opcode_idix_p1             (opcode_idix_p1),
    .rotate_shift_right_idix_p1 (rotate_shift_right_idix_p1),
    .uop_cnt_idix_p1            (uop_cnt_idix_p1),
    .rs_idix_p1                 (rs_idix_p1),
    .rt_idix_p1                 (rt_idix_p1),
    .rd_idix_p1                 (rd_idix_p1),
    .wr_idix_p1                 (wr_idix_p1),
    .excep_idix_p1              (excep_idix_p1),
    .pc_p1                      (pc_p1),
    .inst_idix_p1               (inst_idix_p1),
    .halted                     (halted)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [15:0] inst, input logic [15:0] pc);
    if_valid = v;
    if_inst  = inst;
    if_pc    = pc;
  endtask

  // cls = {execute_valid, ldst_valid, jmp, branch, rotate_shift_right, wr}
  task automatic dec_vec(input string tag, input logic [15:0] inst, input logic [15:0] pc,
                         input logic [5:0] cls, input logic [2:0] rd, input logic [25:0] uop);
    logic [4:0] op;
    op = inst[15:11];
    drive(1'b1, inst, pc);
    tick;
    check({tag, "_valid"}, valid_idix_p1, 1);
    check({tag, "_opcode"}, opcode_idix_p1, op);
    check({tag, "_cls"}, {execute_valid_idix_p1, ldst_valid_idix_p1, jmp_idix_p1,
                          branch_idix_p1, rotate_shift_right_idix_p1, wr_idix_p1}, cls);
    check({tag, "_rd"}, rd_idix_p1, rd);
    check({tag, "_uop"}, uop_cnt_idix_p1, uop);
    check({tag, "_pc"}, pc_p1, pc);
  endtask

  initial begin
    rst = 1'b1; flush = 1'b0; ex_ready = 1'b1;
    drive(1'b1, 16'h4223, 16'h0010);

    // 1: reset
    repeat (3) tick;
    check("rst_valid", valid_idix_p1, 0);
    check("rst_ready", if_ready, 0);
    check("rst_uop", uop_cnt_idix_p1, 0);
    check("rst_pc", pc_p1, 0);
    check("rst_halted", halted, 0);
    rst = 1'b0;
    drive(1'b0, 16'h0, 16'h0);
    tick;
    check("ready_after_rst", if_ready, 1);

    // 2: single-instruction decode
    dec_vec("addi", 16'h4223, 16'h0010, 6'b100001, 3'd1, 26'h0000001);
    check("addi_rs", rs_idix_p1, 2);
    dec_vec("rori", 16'hB125, 16'h0011, 6'b100011, 3'd1, 26'h0000040);
    dec_vec("ror_r", 16'hD10A, 16'h0012, 6'b100011, 3'd2, 26'h0000040);
    dec_vec("jal", 16'h3000, 16'h0013, 6'b001001, 3'd7, 26'h1000000);
    dec_vec("bnez", 16'h6900, 16'h0014, 6'b000100, 3'd0, 26'h0080000);
    dec_vec("lbi", 16'hC5FF, 16'h0015, 6'b100001, 3'd5, 26'h0002000);
    dec_vec("ld", 16'h8A00, 16'h0016, 6'b010001, 3'd0, 26'h0008000);
    drive(1'b0, 16'h0, 16'h0);
    tick;
    check("idle_valid", valid_idix_p1, 0);

    // 3: stall with skid, then in-order drain
    k = 0;
    for (int c = 0; c < 12; c++) begin
      ex_ready = (c >= 3);
      drive(k < 4, 16'h4200 | 16'(k), 16'h0020 + 16'(k));
      if (c == 2) begin
        check("stall_pc_hold", pc_p1, 16'h0020);
        check("stall_valid", valid_idix_p1, 1);
        check("stall_ready", if_ready, 0);
      end
      if (valid_idix_p1 && ex_ready) begin
        iss_pc.push_back({16'h0, pc_p1});
        iss_cyc.push_back(c);
      end
      if (if_valid && if_ready) k++;
      tick;
    end
    check("stream_count", iss_pc.size(), 4);
    for (int i = 0; i < 4; i++) begin
      check("stream_pc", (i < iss_pc.size()) ? iss_pc[i] : 32'hDEAD, 32'h20 + i);
      check("stream_cycle", (i < iss_cyc.size()) ? iss_cyc[i] : -1, 3 + i);
    end

    // 4: STU sequencing
    ex_ready = 1'b1;
    drive(1'b1, 16'h9962, 16'h0040);
    tick;
    drive(1'b0, 16'h0, 16'h0);
    check("stu0_valid", valid_idix_p1, 1);
    check("stu0_ldst", ldst_valid_idix_p1, 1);
    check("stu0_wr", wr_idix_p1, 0);
    check("stu0_pc", pc_p1, 16'h0040);
    check("stu0_uop", uop_cnt_idix_p1, 26'h0020000);
    check("stu_ready_uop2", if_ready, 0);
    tick;
    check("stu1_valid", valid_idix_p1, 1);
    check("stu1_ex", execute_valid_idix_p1, 1);
    check("stu1_ldst", ldst_valid_idix_p1, 0);
    check("stu1_wr", wr_idix_p1, 1);
    check("stu1_rd", rd_idix_p1, 1);
    check("stu1_uop", uop_cnt_idix_p1, 26'h0000001);
    check("stu1_pc", pc_p1, 16'h0040);
    check("stu1_inst", inst_idix_p1, 16'h9962);
    tick;
    check("stu_done_valid", valid_idix_p1, 0);
    check("stu_done_ready", if_ready, 1);

    // 5: flush with skid full, and flush discarding a handshake
    ex_ready = 1'b0;
    drive(1'b1, 16'h4201, 16'h0050);
    tick;
    drive(1'b1, 16'h4202, 16'h0051);
    tick;
    check("fl_pre_ready", if_ready, 0);
    check("fl_pre_pc", pc_p1, 16'h0050);
    flush = 1'b1;
    drive(1'b1, 16'h4203, 16'h0052);
    tick;
    flush = 1'b0;
    check("fl_valid", valid_idix_p1, 0);
    check("fl_ready", if_ready, 1);
    ex_ready = 1'b1;
    drive(1'b1, 16'h4204, 16'h0060);
    tick;
    drive(1'b0, 16'h0, 16'h0);
    check("fl_next_valid", valid_idix_p1, 1);
    check("fl_next_pc", pc_p1, 16'h0060);
    tick;
    check("fl_no_stale", valid_idix_p1, 0);
    flush = 1'b1;
    drive(1'b1, 16'h4205, 16'h0061);
    tick;
    flush = 1'b0;
    drive(1'b0, 16'h0, 16'h0);
    check("fl_discard0", valid_idix_p1, 0);
    tick;
    check("fl_discard1", valid_idix_p1, 0);

    // 6: HALT then SIIC
    drive(1'b1, 16'h0000, 16'h0070);
    tick;
    drive(1'b1, 16'h4223, 16'h0072);
    check("halt_valid", valid_idix_p1, 1);
    check("halt_cls", {execute_valid_idix_p1, ldst_valid_idix_p1, jmp_idix_p1, branch_idix_p1}, 0);
    check("halt_pc", pc_p1, 16'h0070);
    check("halt_ready", if_ready, 0);
    tick;
    check("halt_once", valid_idix_p1, 0);
    check("halted", halted, 1);
    cnt_rdy = 0;
    cnt_vld = 0;
    for (int c = 0; c < 10; c++) begin
      if (if_ready) cnt_rdy++;
      if (valid_idix_p1) cnt_vld++;
      tick;
    end
    check("halt_ready_cycles", cnt_rdy, 0);
    check("halt_valid_cycles", cnt_vld, 0);
    check("halted_hold", halted, 1);
    rst = 1'b1;
    tick;
    rst = 1'b0;
    drive(1'b0, 16'h0, 16'h0);
    tick;
    check("halt_rst_cleared", halted, 0);
    drive(1'b1, 16'h1000, 16'h0080);
    tick;
    drive(1'b1, 16'h4223, 16'h0082);
    check("siic_valid", valid_idix_p1, 1);
    check("siic_excep", excep_idix_p1, 1);
    check("siic_wr", wr_idix_p1, 0);
    check("siic_ex", execute_valid_idix_p1, 0);
    check("siic_pc", pc_p1, 16'h0080);
    tick;
    drive(1'b0, 16'h0, 16'h0);
    check("post_siic_excep", excep_idix_p1, 0);
    check("post_siic_wr", wr_idix_p1, 1);
    check("post_siic_pc", pc_p1, 16'h0082);
    tick;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
